// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - round-robin sequencer driving the glitch-free clock mux select
module clk_switch_ctrl #(
    parameter int NREQ       = 2,
    parameter int SETTLE_CYC = 8,
    parameter int DWELL_CYC  = 16,
    parameter int CNT_W      = 8,
    localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_sel,
    output logic [NREQ-1:0] ack,
    output logic            select,
    output logic            busy,
    output logic [ID_W-1:0] grant_id,
    output logic            dropped
);

    typedef enum logic [2:0] {IDLE, GRANT, SETTLE, ACK, DWELL} state_t;

    state_t          state;
    logic [CNT_W-1:0] counter;
    logic [ID_W-1:0] rr_ptr;
    logic            target;
    logic            switched;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] ptr_next;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(rr_ptr) + i) % NREQ);
            end
        end
        ptr_next = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            counter  <= '0;
            rr_ptr   <= '0;
            target   <= 1'b0;
            switched <= 1'b0;
            select   <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            dropped  <= 1'b0;
        end else begin
            ack     <= '0;
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        target   <= req_sel[pick];
                        rr_ptr   <= ptr_next;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (target == select) begin
                        ack      <= NREQ'(1) << grant_id;
                        switched <= 1'b0;
                        state    <= ACK;
                    end else begin
                        select   <= target;
                        counter  <= CNT_W'(SETTLE_CYC - 1);
                        switched <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (counter == '0) begin
                        // A requester that gave up mid-handover still leaves the new clock in place.
                        if (req[grant_id]) begin
                            ack   <= NREQ'(1) << grant_id;
                            state <= ACK;
                        end else begin
                            dropped <= 1'b1;
                            counter <= CNT_W'(DWELL_CYC - 1);
                            state   <= DWELL;
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ACK: begin
                    if (switched) begin
                        counter <= CNT_W'(DWELL_CYC - 1);
                        state   <= DWELL;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DWELL: begin
                    if (counter == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
